serial_bus_monitor: RTL and testbench
=====================================

SERIAL_BUS_MONITOR -- requirements
Module: serial_bus_monitor

Interface
REQ-001 The block SHALL take parameter CLKS_PER_BIT, default 87, giving clk cycles per serial bit (115200 baud at 10 MHz).
REQ-002 The block SHALL take parameter TIMEOUT_CYCLES, default 1000000, giving the maximum idle gap between bytes of one command frame.
REQ-003 clk  input  1  system clock, 10 MHz; reset_n  input  1  reset; reset reset_n, asynchronous, active-low; clock clk.
REQ-004 rx_serial  input  1  host-to-monitor serial line, idle high, asynchronous to clk.
REQ-005 tx_serial  output  1  monitor-to-host serial line, idle high.
REQ-006 bus_req  output  1  request for one bus access.
REQ-007 bus_addr  output  16  access address; bus_we  output  1  1=write, 0=read; bus_wdata  output  8  write data.
REQ-008 bus_rdata  input  8  read data, valid when bus_ack=1; bus_ack  input  1  one-cycle access-complete strobe.
REQ-009 busy  output  1  high from first command byte until the response stop bit ends.

Function
REQ-010 The rx path SHALL pass rx_serial through a two-flop synchronizer before use.
REQ-011 Rx: falling edge starts a byte; the start bit is rechecked at CLKS_PER_BIT/2 and, if high, ignored; data bits LSB first sampled at bit centres; stop bit sampled at its centre.
REQ-012 A stop bit sampled low (framing error) SHALL discard the byte and return the command FSM to IDLE with no response.
REQ-013 Tx: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each CLKS_PER_BIT cycles; tx_serial=1 otherwise.
REQ-014 Command FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, BUS, RESP.
REQ-015 IDLE: 0x52 ('R') -> ADDR_HI read; 0x57 ('W') -> ADDR_HI write; any other byte -> RESP sending 0x3F ('?').
REQ-016 ADDR_HI captures bus_addr[15:8]; ADDR_LO captures bus_addr[7:0]; read then goes to BUS, write goes to DATA; DATA captures bus_wdata, then BUS.
REQ-017 BUS: bus_req rises the cycle after entry and holds, with addr/we/wdata stable, until the cycle bus_ack is sampled high; bus_req is low the following cycle.
REQ-018 bus_rdata SHALL be captured in the bus_ack cycle; response is that byte for reads, 0x2B ('+') for writes.
REQ-019 bus_ack while bus_req is low SHALL be ignored.
REQ-020 RESP: transmit response byte(s), then IDLE; bytes received during RESP SHALL be dropped.
REQ-021 In ADDR_HI/ADDR_LO/DATA, an inter-byte gap exceeding TIMEOUT_CYCLES SHALL return to IDLE with no response and no bus access; timer restarts on each received byte.
REQ-022 BUS has no timeout; bus_req waits for bus_ack indefinitely.

Reset
REQ-023 During reset: tx_serial=1, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, busy=0, FSM=IDLE, rx/tx bit counters and timeout counter cleared.
REQ-024 Reset asserted mid-byte or mid-access SHALL abort it immediately; tx_serial goes high asynchronously.

Configuration
REQ-025 Macro SERIAL_MONITOR_CHECKSUM_EN defined: each command frame SHALL carry a trailing byte equal to XOR of all prior frame bytes, checked in an extra CHECK state before BUS.
REQ-026 With the macro, mismatch SHALL respond 0x21 ('!') without bus access, and every success response SHALL be followed by a second byte = response XOR command byte.
REQ-027 Without the macro, no CHECK state exists and frames/responses are exactly as REQ-015..REQ-018.

Structure
REQ-028 Command codes (0x52, 0x57), response codes (0x3F, 0x2B, 0x21) and the FSM state enum SHALL live in shared package serial_monitor_pkg.
REQ-029 Serial bit timing (rx and tx shifters) SHALL be one sub-module serial_byte_io; the command FSM and bus handshake stay in the top.

Verification
REQ-030 Send 52 12 34, ack with bus_rdata=A5 after 5 cycles -> bus_addr=1234, bus_we=0, bus_req high exactly until ack, tx emits A5.
REQ-031 Send 57 9C 00 5A, ack -> bus_addr=9C00, bus_we=1, bus_wdata=5A, tx emits 2B.
REQ-032 Send 41 -> no bus_req, tx emits 3F, busy falls after stop bit.
REQ-033 Send 52 12, idle TIMEOUT_CYCLES+10, then 57 00 01 FF -> no read access; one write to 0001, response 2B.
REQ-034 Send byte with stop bit 0, then 52 00 00 -> first byte discarded; read of 0000 completes normally.
REQ-035 Assert reset_n low mid-response bit 4 -> tx_serial=1, bus_req=0 immediately; after release, 52 00 10 completes; with SERIAL_MONITOR_CHECKSUM_EN, 52 12 34 00 -> tx 21, no bus_req.

Source files
------------

// File: rtl/serial_monitor_pkg.sv
// Shared command/response codes and state encodings for the serial bus monitor.
// SERIAL_MONITOR_CHECKSUM_EN adds the CHECK state used for trailing-checksum frames.
package serial_monitor_pkg;

    localparam logic [7:0] CMD_READ     = 8'h52;
    localparam logic [7:0] CMD_WRITE    = 8'h57;
    localparam logic [7:0] RESP_UNKNOWN = 8'h3F;
    localparam logic [7:0] RESP_OK      = 8'h2B;
    localparam logic [7:0] RESP_BAD     = 8'h21;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        DATA,
`ifdef SERIAL_MONITOR_CHECKSUM_EN
        CHECK,
`endif
        BUS,
        RESP
    } cmd_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/serial_bus_monitor_if.sv
// Single-access bus between the monitor (master) and the target (slave).
interface serial_bus_monitor_if;

    logic        bus_req;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_addr, bus_we, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_addr, bus_we, bus_wdata,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/serial_byte_io.sv
// 8N1 byte receiver and transmitter sharing one bit period of CLKS_PER_BIT clocks.
module serial_byte_io
    import serial_monitor_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_serial,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_error,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_serial
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    rx_state_t     rx_state, rx_state_next;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_idx;
    logic [8:0]    tx_shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_state <= RX_IDLE;
        else          rx_state <= rx_state_next;
    end

    // Start is a true falling edge so a line held low after a framing error is not re-read.
    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_state_next = RX_START;
            RX_START: if (rx_cnt == HALF) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == FULL && rx_idx == 3'd7) rx_state_next = RX_STOP;
            RX_STOP:  if (rx_cnt == FULL) rx_state_next = RX_IDLE;
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_meta  <= rx_serial;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            if (rx_state == RX_IDLE || rx_state_next != rx_state || rx_cnt == FULL)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + CW'(1);
            if (rx_state == RX_IDLE)
                rx_idx <= '0;
            if (rx_state == RX_DATA && rx_cnt == FULL) begin
                rx_data <= {rx_sync, rx_data[7:1]};
                rx_idx  <= rx_idx + 3'd1;
            end
            if (rx_state == RX_STOP && rx_cnt == FULL) begin
                rx_valid <= rx_sync;
                rx_error <= !rx_sync;
            end
        end
    end

    // tx_idx 0 is the start bit, 1..8 data, 9 the stop bit; busy drops when the stop bit ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_busy   <= 1'b0;
            tx_serial <= 1'b1;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shift  <= '1;
        end else if (!tx_busy) begin
            tx_serial <= 1'b1;
            if (tx_start) begin
                tx_busy   <= 1'b1;
                tx_serial <= 1'b0;
                tx_shift  <= {1'b1, tx_data};
                tx_cnt    <= '0;
                tx_idx    <= '0;
            end
        end else if (tx_cnt == FULL) begin
            tx_cnt <= '0;
            if (tx_idx == 4'd9) begin
                tx_busy   <= 1'b0;
                tx_serial <= 1'b1;
            end else begin
                tx_serial <= tx_shift[0];
                tx_shift  <= {1'b1, tx_shift[8:1]};
                tx_idx    <= tx_idx + 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_bus_monitor.sv
// Serial command monitor: 'R'/'W' frames from the host become single bus accesses.
// SERIAL_MONITOR_CHECKSUM_EN adds a trailing XOR checksum byte and a second response byte.
module serial_bus_monitor
    import serial_monitor_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 87,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_serial,
    output logic tx_serial,
    output logic busy,
    serial_bus_monitor_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef SERIAL_MONITOR_CHECKSUM_EN
    localparam cmd_state_t FRAME_END = CHECK;
`else
    localparam cmd_state_t FRAME_END = BUS;
`endif

    cmd_state_t    state, state_next;
    logic          rx_valid, rx_error, tx_start, tx_busy;
    logic [7:0]    rx_data, resp_byte, resp_value;
    logic          load_resp, tx_sent, frame_state, timeout;
    logic [TW-1:0] timer;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
    logic [7:0]    cmd_byte, csum, resp_second;
    logic          resp_more, resp_success;
`endif

    serial_byte_io #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_io (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_serial (rx_serial),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_error  (rx_error),
        .tx_start  (tx_start),
        .tx_data   (resp_byte),
        .tx_busy   (tx_busy),
        .tx_serial (tx_serial)
    );

`ifdef SERIAL_MONITOR_CHECKSUM_EN
    assign frame_state = (state == ADDR_HI) || (state == ADDR_LO) || (state == DATA) || (state == CHECK);
`else
    assign frame_state = (state == ADDR_HI) || (state == ADDR_LO) || (state == DATA);
`endif
    assign timeout = (timer >= TW'(TIMEOUT_CYCLES));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_resp  = 1'b0;
        resp_value = RESP_UNKNOWN;
        tx_start   = 1'b0;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
        resp_success = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
                        state_next = ADDR_HI;
                    end else begin
                        state_next = RESP;
                        load_resp  = 1'b1;
                    end
                end
            end
            ADDR_HI: if (rx_valid) state_next = ADDR_LO;
            ADDR_LO: if (rx_valid) state_next = bus.bus_we ? DATA : FRAME_END;
            DATA:    if (rx_valid) state_next = FRAME_END;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
            CHECK: begin
                if (rx_valid) begin
                    if (rx_data == csum) begin
                        state_next = BUS;
                    end else begin
                        state_next = RESP;
                        load_resp  = 1'b1;
                        resp_value = RESP_BAD;
                    end
                end
            end
`endif
            BUS: begin
                if (bus.bus_req && bus.bus_ack) begin
                    state_next = RESP;
                    load_resp  = 1'b1;
                    resp_value = bus.bus_we ? RESP_OK : bus.bus_rdata;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
                    resp_success = 1'b1;
`endif
                end
            end
            RESP: begin
                if (!tx_sent)
                    tx_start = !tx_busy;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
                else if (!tx_busy && !resp_more)
                    state_next = IDLE;
`else
                else if (!tx_busy)
                    state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
        // A broken or stalled frame is abandoned silently before any bus access.
        if (frame_state && (rx_error || (timeout && !rx_valid)))
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            resp_byte     <= '0;
            tx_sent       <= 1'b0;
            timer         <= '0;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
            cmd_byte      <= '0;
            csum          <= '0;
            resp_second   <= '0;
            resp_more     <= 1'b0;
`endif
        end else begin
            timer <= (frame_state && !rx_valid && state_next == state) ? timer + TW'(1) : '0;
            bus.bus_req <= (state == BUS) && !(bus.bus_req && bus.bus_ack);
            if (rx_valid) begin
                case (state)
                    IDLE:    bus.bus_we          <= (rx_data == CMD_WRITE);
                    ADDR_HI: bus.bus_addr[15:8]  <= rx_data;
                    ADDR_LO: bus.bus_addr[7:0]   <= rx_data;
                    DATA:    bus.bus_wdata       <= rx_data;
                    default: ;
                endcase
`ifdef SERIAL_MONITOR_CHECKSUM_EN
                if (state == IDLE) begin
                    cmd_byte <= rx_data;
                    csum     <= rx_data;
                end else if (frame_state) begin
                    csum <= csum ^ rx_data;
                end
`endif
            end
            if (load_resp) begin
                resp_byte <= resp_value;
                tx_sent   <= 1'b0;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
                resp_second <= resp_value ^ cmd_byte;
                resp_more   <= resp_success;
`endif
            end else if (tx_start) begin
                tx_sent <= 1'b1;
            end
`ifdef SERIAL_MONITOR_CHECKSUM_EN
            else if (state == RESP && tx_sent && !tx_busy && resp_more) begin
                resp_byte <= resp_second;
                resp_more <= 1'b0;
                tx_sent   <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_serial_bus_monitor.sv
// Scoreboard bench: stimulus pushes expected bus accesses and tx bytes, monitors pop and compare.
// Frames gain a checksum byte and success responses a second byte when SERIAL_MONITOR_CHECKSUM_EN is set.
module tb_serial_bus_monitor;

    localparam int CLKS = 8;
    localparam int TMO  = 2000;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } access_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic rx_serial = 1'b1;
    logic tx_serial, busy;

    access_t    exp_bus[$];
    logic [7:0] exp_tx[$];
    int total = 0;
    int bad = 0;
    int reset_count = 0;
    int poke_req = 0;

    serial_bus_monitor_if bus_if();

    serial_bus_monitor #(.CLKS_PER_BIT(CLKS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_serial (rx_serial),
        .tx_serial (tx_serial),
        .busy      (busy),
        .bus       (bus_if.master)
    );

    always #5 clk = ~clk;

    always @(negedge reset_n) reset_count++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input logic [31:0] actual);
        total++;
        bad++;
        $display("[TB] FAIL %s: got %0h expected nothing", name, actual);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_val);
        rx_serial = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rx_serial = stop_val;
        repeat (CLKS) @(negedge clk);
        rx_serial = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input int n);
        logic [7:0] f [4];
        logic [7:0] cs;
        f[0] = b0; f[1] = b1; f[2] = b2; f[3] = b3;
        cs = 8'h00;
        for (int i = 0; i < n; i++) begin
            applyStimulus(f[i], 1'b1);
            cs = cs ^ f[i];
        end
`ifdef SERIAL_MONITOR_CHECKSUM_EN
        applyStimulus(cs, 1'b1);
`endif
    endtask

    task automatic expectResp(input logic [7:0] r, input logic [7:0] cmd, input bit success);
        exp_tx.push_back(r);
`ifdef SERIAL_MONITOR_CHECKSUM_EN
        if (success) exp_tx.push_back(r ^ cmd);
`endif
    endtask

    task automatic expectAccess(input logic [15:0] a, input logic w, input logic [7:0] d, input logic [7:0] r);
        exp_bus.push_back('{addr: a, we: w, wdata: d, rdata: r});
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || exp_tx.size() != 0 || exp_bus.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", 32'(n < 20000), 1);
        repeat (2 * CLKS) @(negedge clk);
        checkOutput("tx_queue_left", exp_tx.size(), 0);
        checkOutput("bus_queue_left", exp_bus.size(), 0);
        checkOutput("tx_idle_high", tx_serial, 1);
    endtask

    // Decodes every tx byte; bytes cut short by a reset are dropped rather than compared.
    initial begin : tx_monitor
        logic prev;
        logic stop_bit;
        logic [7:0] b;
        int rc;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n && prev && !tx_serial) begin
                rc = reset_count;
                repeat (CLKS / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKS) @(negedge clk);
                    b[i] = tx_serial;
                end
                repeat (CLKS) @(negedge clk);
                stop_bit = tx_serial;
                if (rc != reset_count) begin
                    $display("[TB] tx byte aborted by reset");
                end else if (exp_tx.size() == 0) begin
                    failNow("unexpected_tx_byte", b);
                end else begin
                    checkOutput("tx_byte", b, exp_tx.pop_front());
                    checkOutput("tx_stop_bit", stop_bit, 1);
                end
            end
            prev = tx_serial;
        end
    end

    // Acts as the bus target: checks each request and acks it five cycles later.
    initial begin : bus_monitor
        access_t e;
        logic held;
        int poke_done;
        poke_done = 0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_n && bus_if.bus_req) begin
                if (exp_bus.size() == 0) begin
                    failNow("unexpected_bus_req", bus_if.bus_addr);
                    e = '{addr: bus_if.bus_addr, we: bus_if.bus_we, wdata: bus_if.bus_wdata, rdata: 8'h00};
                end else begin
                    e = exp_bus.pop_front();
                    checkOutput("bus_addr", bus_if.bus_addr, e.addr);
                    checkOutput("bus_we", bus_if.bus_we, e.we);
                    if (e.we) checkOutput("bus_wdata", bus_if.bus_wdata, e.wdata);
                end
                held = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    if (!(bus_if.bus_req && bus_if.bus_addr == e.addr && bus_if.bus_we == e.we)) held = 1'b0;
                end
                checkOutput("bus_req_held", held, 1);
                bus_if.bus_rdata = e.rdata;
                bus_if.bus_ack   = 1'b1;
                @(negedge clk);
                bus_if.bus_ack   = 1'b0;
                bus_if.bus_rdata = 8'h00;
                checkOutput("bus_req_drop", bus_if.bus_req, 0);
            end else if (poke_req != poke_done) begin
                bus_if.bus_rdata = 8'hEE;
                bus_if.bus_ack   = 1'b1;
                @(negedge clk);
                bus_if.bus_ack   = 1'b0;
                bus_if.bus_rdata = 8'h00;
                poke_done++;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected test end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx_serial", tx_serial, 1);
        checkOutput("reset_bus_req", bus_if.bus_req, 0);
        checkOutput("reset_bus_we", bus_if.bus_we, 0);
        checkOutput("reset_bus_addr", bus_if.bus_addr, 0);
        checkOutput("reset_bus_wdata", bus_if.bus_wdata, 0);
        checkOutput("reset_busy", busy, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] read 52 12 34");
        poke_req++;
        repeat (4) @(negedge clk);
        expectAccess(16'h1234, 1'b0, 8'h00, 8'hA5);
        expectResp(8'hA5, 8'h52, 1'b1);
        sendFrame(8'h52, 8'h12, 8'h34, 8'h00, 3);
        waitIdle();

        $display("[TB] write 57 9C 00 5A");
        expectAccess(16'h9C00, 1'b1, 8'h5A, 8'h00);
        expectResp(8'h2B, 8'h57, 1'b1);
        sendFrame(8'h57, 8'h9C, 8'h00, 8'h5A, 4);
        waitIdle();

        $display("[TB] unknown command 41");
        expectResp(8'h3F, 8'h41, 1'b0);
        applyStimulus(8'h41, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("busy_during_resp", busy, 1);
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_after_stop", exp_tx.size(), 0);
        waitIdle();

        $display("[TB] timeout after 52 12");
        expectAccess(16'h0001, 1'b1, 8'hFF, 8'h00);
        expectResp(8'h2B, 8'h57, 1'b1);
        applyStimulus(8'h52, 1'b1);
        applyStimulus(8'h12, 1'b1);
        repeat (TMO + 10) @(negedge clk);
        checkOutput("busy_after_timeout", busy, 0);
        sendFrame(8'h57, 8'h00, 8'h01, 8'hFF, 4);
        waitIdle();

        $display("[TB] framing error then read 0000");
        expectAccess(16'h0000, 1'b0, 8'h00, 8'h3C);
        expectResp(8'h3C, 8'h52, 1'b1);
        applyStimulus(8'h57, 1'b0);
        repeat (2 * CLKS) @(negedge clk);
        checkOutput("busy_after_frame_err", busy, 0);
        sendFrame(8'h52, 8'h00, 8'h00, 8'h00, 3);
        waitIdle();

        $display("[TB] reset during response bit 4");
        expectAccess(16'h1234, 1'b0, 8'h00, 8'h0F);
        sendFrame(8'h52, 8'h12, 8'h34, 8'h00, 3);
        n = 0;
        while (tx_serial && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("resp_started", 32'(n < 5000), 1);
        repeat (5 * CLKS + CLKS / 2) @(negedge clk);
        checkOutput("tx_bit4_low", tx_serial, 0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset_mid_tx_serial", tx_serial, 1);
        checkOutput("reset_mid_bus_req", bus_if.bus_req, 0);
        checkOutput("reset_mid_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * CLKS) @(negedge clk);
        expectAccess(16'h0010, 1'b0, 8'h00, 8'h7E);
        expectResp(8'h7E, 8'h52, 1'b1);
        sendFrame(8'h52, 8'h00, 8'h10, 8'h00, 3);
        waitIdle();

`ifdef SERIAL_MONITOR_CHECKSUM_EN
        $display("[TB] bad checksum 52 12 34 00");
        expectResp(8'h21, 8'h52, 1'b0);
        applyStimulus(8'h52, 1'b1);
        applyStimulus(8'h12, 1'b1);
        applyStimulus(8'h34, 1'b1);
        applyStimulus(8'h00, 1'b1);
        waitIdle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
